// File: rtl/reg_write_arbiter_if.sv
// Interface for reg_write_arbiter: two writeback request channels and the
// registered register-file write port.
// slave  : the arbiter side (takes requests, drives the write port)
// master : the requester / register-file side
interface reg_write_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              reg_write;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic              grant_id;
    logic [1:0]        pending;

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready,
        output reg_write, write_reg, write_data, grant_id, pending
    );

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready,
        input  reg_write, write_reg, write_data, grant_id, pending
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: shares one register-file write port between the ALU
// writeback (req0) and load writeback (req1). Each requester owns a one-entry
// holding register; the oldest full hold wins, ties broken round-robin.
// Optional macro ZERO_REG_GUARD_EN: writes to address 0 are accepted but
// dropped (never held, never issued).
module reg_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    reg_write_arbiter_if.slave   bus
);

    logic              h0_full_q, h0_full_d, h1_full_q, h1_full_d;
    logic [ADDR_W-1:0] h0_addr_q, h0_addr_d, h1_addr_q, h1_addr_d;
    logic [DATA_W-1:0] h0_data_q, h0_data_d, h1_data_q, h1_data_d;
    logic              h0_age_q,  h0_age_d,  h1_age_q,  h1_age_d;
    logic              rr_q, rr_d;
    logic              reg_write_q, reg_write_d;
    logic [ADDR_W-1:0] write_reg_q, write_reg_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic              grant_id_q, grant_id_d;
    logic [1:0]        pending_q, pending_d;

    logic grant0, grant1, rdy0, rdy1, acc0, acc1, fill0, fill1, keep0, keep1;

    // Arbitration from hold state only: age first, then the rr pointer.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (h0_full_q && h1_full_q) begin
            if (h0_age_q != h1_age_q) grant0 = h0_age_q;
            else                      grant0 = ~rr_q;
            grant1 = ~grant0;
        end else begin
            grant0 = h0_full_q;
            grant1 = h1_full_q;
        end
    end

    assign rdy0 = ~h0_full_q | grant0;
    assign rdy1 = ~h1_full_q | grant1;
    assign acc0 = bus.req0_valid & rdy0;
    assign acc1 = bus.req1_valid & rdy1;

    // A guarded address-0 write is acknowledged but never lands in the hold.
    always_comb begin
`ifdef ZERO_REG_GUARD_EN
        fill0 = acc0 && (bus.req0_addr != '0);
        fill1 = acc1 && (bus.req1_addr != '0);
`else
        fill0 = acc0;
        fill1 = acc1;
`endif
    end

    // Hold, age, rr and issue-register next state.
    always_comb begin
        keep0     = h0_full_q & ~grant0;
        keep1     = h1_full_q & ~grant1;
        h0_full_d = fill0 | keep0;
        h1_full_d = fill1 | keep1;
        h0_addr_d = fill0 ? bus.req0_addr : h0_addr_q;
        h0_data_d = fill0 ? bus.req0_data : h0_data_q;
        h1_addr_d = fill1 ? bus.req1_addr : h1_addr_q;
        h1_data_d = fill1 ? bus.req1_data : h1_data_q;

        // Only a hold that survives the edge next to a freshly filled one is older.
        h0_age_d = keep0 & fill1;
        h1_age_d = keep1 & fill0;

        // After a contested cycle the loser gets the next tie.
        rr_d = (h0_full_q && h1_full_q) ? grant0 : rr_q;

        reg_write_d  = grant0 | grant1;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        grant_id_d   = grant_id_q;
        if (grant0) begin
            write_reg_d  = h0_addr_q;
            write_data_d = h0_data_q;
            grant_id_d   = 1'b0;
        end else if (grant1) begin
            write_reg_d  = h1_addr_q;
            write_data_d = h1_data_q;
            grant_id_d   = 1'b1;
        end

        pending_d = {1'b0, h0_full_d} + {1'b0, h1_full_d};
    end

    // State registers; reset drops any in-flight writes immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h0_full_q    <= 1'b0;
            h1_full_q    <= 1'b0;
            h0_addr_q    <= '0;
            h1_addr_q    <= '0;
            h0_data_q    <= '0;
            h1_data_q    <= '0;
            h0_age_q     <= 1'b0;
            h1_age_q     <= 1'b0;
            rr_q         <= 1'b0;
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            grant_id_q   <= 1'b0;
            pending_q    <= 2'd0;
        end else begin
            h0_full_q    <= h0_full_d;
            h1_full_q    <= h1_full_d;
            h0_addr_q    <= h0_addr_d;
            h1_addr_q    <= h1_addr_d;
            h0_data_q    <= h0_data_d;
            h1_data_q    <= h1_data_d;
            h0_age_q     <= h0_age_d;
            h1_age_q     <= h1_age_d;
            rr_q         <= rr_d;
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            grant_id_q   <= grant_id_d;
            pending_q    <= pending_d;
        end
    end

    assign bus.req0_ready = rdy0;
    assign bus.req1_ready = rdy1;
    assign bus.reg_write  = reg_write_q;
    assign bus.write_reg  = write_reg_q;
    assign bus.write_data = write_data_q;
    assign bus.grant_id   = grant_id_q;
    assign bus.pending    = pending_q;

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: req0 (ALU writeback) and req1 (load writeback).
- Each requester has a one-entry holding register.
- Age-ordered, round-robin-tiebroken arbiter issues one registered write per cycle onto reg_write/write_reg/write_data, which connect directly to the register file write inputs.

Parameters:
DATA_W, 32, width of write data
ADDR_W, 5, width of register address

Ports:
clk  input  1  clock; all state updates on posedge
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has a write
req0_addr  input  ADDR_W  requester 0 destination register
req0_data  input  DATA_W  requester 0 write value
req0_ready  output  1  requester 0 write accepted this edge if valid
req1_valid  input  1  requester 1 has a write
req1_addr  input  ADDR_W  requester 1 destination register
req1_data  input  DATA_W  requester 1 write value
req1_ready  output  1  requester 1 write accepted this edge if valid
reg_write  output  1  write enable to register file (registered)
write_reg  output  ADDR_W  destination to register file (registered)
write_data  output  DATA_W  data to register file (registered)
grant_id  output  1  source of current reg_write (0/1), registered
pending  output  2  number of full holding registers (0..2)

Behaviour:
- Reset (async, rst_n=0):
  - holds empty, age flags cleared, rr pointer=0.
  - reg_write=0, write_reg=0, write_data=0, grant_id=0, pending=0.
  - Takes effect immediately, not at the next edge; in-flight writes are discarded.
- Holding register per requester:
  - fields: full, addr, data, age (1 if older than the other full hold).
  - reqN_ready = !holdN_full | grantN (combinational; grant computed from hold state only, never from valid).
  - Accept at posedge when reqN_valid & reqN_ready: hold loads addr/data, full=1.
  - Refill in the same cycle as the hold's grant is legal: hold stays full with new contents.
- Age tracking:
  - A hold accepted while the other hold is full and not being granted is marked younger.
  - Both accepted on the same edge: equal age.
- Grant (combinational each cycle):
  - only hold0 full: grant0.
  - only hold1 full: grant1.
  - both full: the older wins; if equal age, the requester pointed to by rr wins.
  - rr toggles to the non-winner after any cycle where both holds were full; otherwise unchanged.
- Issue:
  - On the grant edge, output regs load the winner: reg_write=1, write_reg, write_data, grant_id.
  - The granted hold clears unless refilled.
  - No grant: reg_write=0; write_reg/write_data/grant_id hold their previous values.
- Latency:
  - accept at edge N -> reg_write high in cycle after edge N+1 -> register file captures at edge N+2.
  - Minimum latency 2 edges; a continuously valid single requester sustains 1 write/cycle.
- Ordering:
  - Writes from one requester issue in acceptance order.
  - Same-address writes from both requesters issue oldest-first, so the last-accepted write wins in the register file.
  - Same-edge acceptances to the same address resolve by rr.
- pending = holds full after the edge, registered.
- Address 0 is treated like any other address unless ZERO_REG_GUARD_EN is defined.

Optional Feature:
- Macro ZERO_REG_GUARD_EN.
- Defined:
  - A write with addr==0 is accepted (ready as normal) but the hold is not filled, never wins arbitration, and produces no reg_write.
  - pending and age flags are unaffected; rr is unaffected.
- Undefined: addr 0 writes issue normally.

Test Plan:
- Reset then idle -> reg_write=0, write_reg=0, write_data=0, pending=0, req0_ready=req1_ready=1. Assert rst_n=0 mid-burst -> outputs zero immediately, no further writes.
- req0 valid at one edge with addr=1, data=0x0000FFFF -> reg_write=1, write_reg=1, write_data=0x0000FFFF, grant_id=0 one edge later; register 1 reads 0x0000FFFF after following edge.
- Both valid same edge: req0 addr=3/data=0xA, req1 addr=4/data=0xB, repeated 4 cycles -> grants alternate 0,1,0,1 starting with 0, no write lost, pending never exceeds 2.
- req1 addr=30/data=0xFFFF0000 accepted while hold0 busy, then req0 addr=30/data=0x1 -> req1's write issues first; register 30 ends 0x1.
- req0 held valid 8 consecutive cycles, req1 idle -> 8 consecutive reg_write pulses, req0_ready stays 1.
- With ZERO_REG_GUARD_EN: req0 addr=0/data=0x5 -> req0_ready=1, no reg_write, pending=0. Without the macro: reg_write=1, write_reg=0.
